// File: rtl/regfile_pkg.sv
// Shared defaults for the multi-port register file: default geometry and
// the register-index type derived from it.
package regfile_pkg;
  localparam int REGFILE_DATA_W = 16;
  localparam int REGFILE_NREGS  = 8;
  localparam int REGFILE_ADDR_W = $clog2(REGFILE_NREGS);

  typedef logic [REGFILE_ADDR_W-1:0] reg_idx_t;
endpackage

// File: rtl/regfile_mp_if.sv
// Bus bundle for regfile_mp: write port, two read ports and scoreboard
// reserve/busy signals. The master drives requests; the slave is the register file.
interface regfile_mp_if
  import regfile_pkg::*;
#(
  parameter int DATA_W = REGFILE_DATA_W,
  parameter int NREGS  = REGFILE_NREGS
);
  localparam int ADDR_W = $clog2(NREGS);

  logic              write;
  logic [ADDR_W-1:0] writenum;
  logic [DATA_W-1:0] data_in;
  logic [ADDR_W-1:0] readnum_a;
  logic [ADDR_W-1:0] readnum_b;
  logic [DATA_W-1:0] data_out_a;
  logic [DATA_W-1:0] data_out_b;
  logic              reserve;
  logic [ADDR_W-1:0] reservenum;
  logic              busy_a;
  logic              busy_b;

  modport master (
    output write, writenum, data_in, readnum_a, readnum_b, reserve, reservenum,
    input  data_out_a, data_out_b, busy_a, busy_b
  );

  modport slave (
    input  write, writenum, data_in, readnum_a, readnum_b, reserve, reservenum,
    output data_out_a, data_out_b, busy_a, busy_b
  );
endinterface

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits tracking pending producers. Reserve sets, write clears,
// and a same-cycle reserve wins so the newly issued producer stays visible.
module regfile_scoreboard #(
  parameter int NREGS    = 8,
  parameter bit ZERO_REG = 1'b0,
  parameter bit BYPASS   = 1'b1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_wr_en,
  input  logic [$clog2(NREGS)-1:0] i_wr_idx,
  input  logic                     i_reserve,
  input  logic [$clog2(NREGS)-1:0] i_rsv_idx,
  input  logic [$clog2(NREGS)-1:0] i_rd_idx_a,
  input  logic [$clog2(NREGS)-1:0] i_rd_idx_b,
  output logic                     o_busy_a,
  output logic                     o_busy_b
);
  localparam int ADDR_W = $clog2(NREGS);

  logic [NREGS-1:0] r_busy;
  logic [NREGS-1:0] w_busy_nxt;
  logic             w_rsv_ok;
  logic             w_fwd_a;
  logic             w_fwd_b;

  assign w_rsv_ok = i_reserve && !(ZERO_REG && (i_rsv_idx == {ADDR_W{1'b0}}));

  // Next busy vector: clear on write first, then set on reserve so set wins.
  always_comb begin
    w_busy_nxt = r_busy;
    if (i_wr_en) begin
      w_busy_nxt[i_wr_idx] = 1'b0;
    end else begin
      w_busy_nxt = r_busy;
    end
    if (w_rsv_ok) begin
      w_busy_nxt[i_rsv_idx] = 1'b1;
    end else begin
      w_busy_nxt[i_rsv_idx] = w_busy_nxt[i_rsv_idx];
    end
    if (ZERO_REG) begin
      w_busy_nxt[0] = 1'b0;
    end else begin
      w_busy_nxt[0] = w_busy_nxt[0];
    end
  end

  // Busy state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_busy <= {NREGS{1'b0}};
    end else begin
      r_busy <= w_busy_nxt;
    end
  end

  // A value being forwarded this cycle is not busy unless it is re-reserved now.
  assign w_fwd_a = BYPASS && i_wr_en && (i_wr_idx == i_rd_idx_a)
                   && !(w_rsv_ok && (i_rsv_idx == i_rd_idx_a));
  assign w_fwd_b = BYPASS && i_wr_en && (i_wr_idx == i_rd_idx_b)
                   && !(w_rsv_ok && (i_rsv_idx == i_rd_idx_b));

  assign o_busy_a = w_fwd_a ? 1'b0 : r_busy[i_rd_idx_a];
  assign o_busy_b = w_fwd_b ? 1'b0 : r_busy[i_rd_idx_b];
endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: one write port, two combinational read ports with
// optional write bypass, optional hard-zero R0 and a busy scoreboard.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W   = REGFILE_DATA_W,
  parameter int NREGS    = REGFILE_NREGS,
  parameter bit BYPASS   = 1'b1,
  parameter bit ZERO_REG = 1'b0
) (
  input  logic         clk,
  input  logic         reset,
  regfile_mp_if.slave  bus
);
  localparam int ADDR_W = $clog2(NREGS);

  logic [DATA_W-1:0] r_regs [NREGS];
  logic              w_wr_en;
  logic [DATA_W-1:0] w_rd_a;
  logic [DATA_W-1:0] w_rd_b;

  // Writes are dropped while reset is held and, with a hard-zero R0, to index 0.
  assign w_wr_en = bus.write && !reset
                   && !(ZERO_REG && (bus.writenum == {ADDR_W{1'b0}}));

  // Register array storage.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) begin
        r_regs[i] <= {DATA_W{1'b0}};
      end
    end else if (w_wr_en) begin
      r_regs[bus.writenum] <= bus.data_in;
    end else begin
      r_regs[bus.writenum] <= r_regs[bus.writenum];
    end
  end

  // Read muxes with optional same-cycle forwarding of the write data.
  always_comb begin
    w_rd_a = r_regs[bus.readnum_a];
    w_rd_b = r_regs[bus.readnum_b];
    if (BYPASS && w_wr_en && (bus.writenum == bus.readnum_a)) begin
      w_rd_a = bus.data_in;
    end else begin
      w_rd_a = r_regs[bus.readnum_a];
    end
    if (BYPASS && w_wr_en && (bus.writenum == bus.readnum_b)) begin
      w_rd_b = bus.data_in;
    end else begin
      w_rd_b = r_regs[bus.readnum_b];
    end
  end

  assign bus.data_out_a = w_rd_a;
  assign bus.data_out_b = w_rd_b;

  regfile_scoreboard #(
    .NREGS    (NREGS),
    .ZERO_REG (ZERO_REG),
    .BYPASS   (BYPASS)
  ) u_scoreboard (
    .clk        (clk),
    .reset      (reset),
    .i_wr_en    (w_wr_en),
    .i_wr_idx   (bus.writenum),
    .i_reserve  (bus.reserve),
    .i_rsv_idx  (bus.reservenum),
    .i_rd_idx_a (bus.readnum_a),
    .i_rd_idx_b (bus.readnum_b),
    .o_busy_a   (bus.busy_a),
    .o_busy_b   (bus.busy_b)
  );
endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: a default instance (16x8, bypass on) and a
// 32x16 instance with bypass off and hard-zero R0.
module tb_regfile_mp;
  logic clk;
  logic reset;
  int   n_tests;
  int   n_fail;

  regfile_mp_if #(.DATA_W(16), .NREGS(8))  if_a ();
  regfile_mp_if #(.DATA_W(32), .NREGS(16)) if_b ();

  regfile_mp #(.DATA_W(16), .NREGS(8), .BYPASS(1'b1), .ZERO_REG(1'b0)) u_dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (if_a)
  );

  regfile_mp #(.DATA_W(32), .NREGS(16), .BYPASS(1'b0), .ZERO_REG(1'b1)) u_dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (if_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_a();
    if_a.write = 1'b0; if_a.writenum = 3'd0; if_a.data_in = 16'h0000;
    if_a.reserve = 1'b0; if_a.reservenum = 3'd0;
  endtask

  task automatic idle_b();
    if_b.write = 1'b0; if_b.writenum = 4'd0; if_b.data_in = 32'h0000_0000;
    if_b.reserve = 1'b0; if_b.reservenum = 4'd0;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset   = 1'b1;
    idle_a(); idle_b();
    if_a.readnum_a = 3'd0; if_a.readnum_b = 3'd0;
    if_b.readnum_a = 4'd0; if_b.readnum_b = 4'd0;
    tick(); tick();
    chk("rst_data_a", 32'(if_a.data_out_a), 32'h0);
    chk("rst_busy_a", 32'(if_a.busy_a), 32'h0);
    reset = 1'b0;

    // 1: load R3, reserve it, then reset mid-cycle
    if_a.write = 1'b1; if_a.writenum = 3'd3; if_a.data_in = 16'h1234;
    tick();
    idle_a();
    if_a.readnum_a = 3'd3;
    if_a.reserve = 1'b1; if_a.reservenum = 3'd3;
    #1 chk("r3_load", 32'(if_a.data_out_a), 32'h1234);
    tick();
    idle_a();
    #1 chk("r3_busy", 32'(if_a.busy_a), 32'h1);
    #2 reset = 1'b1;
    #1 chk("midrst_data", 32'(if_a.data_out_a), 32'h0);
    chk("midrst_busy", 32'(if_a.busy_a), 32'h0);
    if_a.write = 1'b1; if_a.writenum = 3'd3; if_a.data_in = 16'h5555;
    #1 chk("rst_no_bypass", 32'(if_a.data_out_a), 32'h0);
    tick();
    idle_a();
    reset = 1'b0;
    #1 chk("rst_write_lost", 32'(if_a.data_out_a), 32'h0);

    // 2: dual read
    if_a.write = 1'b1; if_a.writenum = 3'd1; if_a.data_in = 16'hAAAA;
    tick();
    if_a.writenum = 3'd6; if_a.data_in = 16'h5555;
    tick();
    idle_a();
    if_a.readnum_a = 3'd1; if_a.readnum_b = 3'd6;
    #1 chk("dual_a", 32'(if_a.data_out_a), 32'hAAAA);
    chk("dual_b", 32'(if_a.data_out_b), 32'h5555);
    if_a.readnum_a = 3'd6;
    #1 chk("same_a", 32'(if_a.data_out_a), 32'h5555);
    chk("same_b", 32'(if_a.data_out_b), 32'h5555);

    // 3: bypass on (A) versus off (B), R2 starts at 0
    if_a.readnum_a = 3'd2;
    if_a.write = 1'b1; if_a.writenum = 3'd2; if_a.data_in = 16'hBEEF;
    if_b.readnum_a = 4'd2;
    if_b.write = 1'b1; if_b.writenum = 4'd2; if_b.data_in = 32'h0000_BEEF;
    #1 chk("byp1_pre", 32'(if_a.data_out_a), 32'hBEEF);
    chk("byp0_pre", if_b.data_out_a, 32'h0);
    tick();
    idle_a(); idle_b();
    #1 chk("byp1_post", 32'(if_a.data_out_a), 32'hBEEF);
    chk("byp0_post", if_b.data_out_a, 32'h0000_BEEF);

    // 4: scoreboard on A
    if_a.readnum_a = 3'd5; if_a.readnum_b = 3'd6;
    if_a.reserve = 1'b1; if_a.reservenum = 3'd5;
    #1 chk("rsv_pre", 32'(if_a.busy_a), 32'h0);
    tick();
    idle_a();
    #1 chk("rsv_post", 32'(if_a.busy_a), 32'h1);
    if_a.write = 1'b1; if_a.writenum = 3'd5; if_a.data_in = 16'h0F0F;
    #1 chk("wr_fwd_busy", 32'(if_a.busy_a), 32'h0);
    tick();
    idle_a();
    #1 chk("wr_clr_busy", 32'(if_a.busy_a), 32'h0);
    chk("r5_data", 32'(if_a.data_out_a), 32'h0F0F);
    if_a.write = 1'b1; if_a.writenum = 3'd5; if_a.data_in = 16'h1357;
    if_a.reserve = 1'b1; if_a.reservenum = 5'd5;
    #1 chk("rsv_wr_pre", 32'(if_a.busy_a), 32'h0);
    tick();
    idle_a();
    #1 chk("rsv_wr_busy", 32'(if_a.busy_a), 32'h1);
    chk("rsv_wr_data", 32'(if_a.data_out_a), 32'h1357);
    if_a.reserve = 1'b1; if_a.reservenum = 3'd5;
    tick();
    idle_a();
    if_a.readnum_b = 3'd5;
    #1 chk("rsv_again", 32'(if_a.busy_b), 32'h1);
    if_a.readnum_b = 3'd6;
    #1 chk("other_free", 32'(if_a.busy_b), 32'h0);

    // 5: hard-zero R0 on B, plus busy without bypass override
    if_b.readnum_a = 4'd0;
    if_b.write = 1'b1; if_b.writenum = 4'd0; if_b.data_in = 32'hFFFF_FFFF;
    if_b.reserve = 1'b1; if_b.reservenum = 4'd0;
    tick();
    idle_b();
    #1 chk("zr_data", if_b.data_out_a, 32'h0);
    chk("zr_busy", 32'(if_b.busy_a), 32'h0);
    if_b.readnum_a = 4'd3;
    if_b.reserve = 1'b1; if_b.reservenum = 4'd3;
    tick();
    idle_b();
    if_b.write = 1'b1; if_b.writenum = 4'd3; if_b.data_in = 32'h0000_0033;
    #1 chk("nobyp_busy_pre", 32'(if_b.busy_a), 32'h1);
    tick();
    idle_b();
    #1 chk("nobyp_busy_post", 32'(if_b.busy_a), 32'h0);

    // 6: wide/deep instance
    if_b.write = 1'b1; if_b.writenum = 4'd15; if_b.data_in = 32'hDEAD_BEEF;
    tick();
    idle_b();
    if_b.readnum_b = 4'd15;
    #1 chk("r15", if_b.data_out_b, 32'hDEAD_BEEF);
    if_b.readnum_b = 4'd14;
    #1 chk("r14", if_b.data_out_b, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
